axi4_video_frame_mux: RTL and testbench
=======================================

# axi4_video_frame_mux

Frame-synchronous 2:1 source scheduler for AXI4-Stream video. It sits between two free-running video sources (pattern generator, camera pipeline) and the downstream video sink. It grants the output to one source at a time and performs source changes only on frame boundaries, so the sink never sees a torn frame. The non-granted source is continuously drained so that free-running sources never stall.

## Interface
- TDATA_WIDTH, 32: pixel word width of all streams.
- X_ACTIVE, 1920: active pixels per line; informational, used by the bench.
- Y_ACTIVE, 1080: active lines per frame; a frame ends at the Y_ACTIVE-th accepted tlast beat.
- clk_i  input  1  single clock for all logic.
- rst_i  input  1  asynchronous, active-high reset.
- sel_i  input  1  requested source (0 = video_0_i, 1 = video_1_i); level, sampled every cycle.
- video_0_i  axi4_stream_if.slave  TDATA_WIDTH  source 0 (tdata, tvalid, tready, tlast, tuser=SOF).
- video_1_i  axi4_stream_if.slave  TDATA_WIDTH  source 1.
- video_o  axi4_stream_if.master  TDATA_WIDTH  muxed output, fully registered.
- active_o  output  1  currently granted source.
- switching_o  output  1  high while in SYNC (no source granted to output).

## Operation
- States: SYNC, PASS. Reset state is SYNC with active_o=0.
- Beat accepted from a source = its tvalid & tready in the same cycle.
- tready of the non-granted source is held at 1; its beats are discarded.
- tready of the granted source = ~video_o.tvalid | video_o.tready.
- SYNC: beats from the granted source are discarded (its tready is 1) until an accepted beat with tuser=1 arrives. That beat is forwarded; ln_cnt is set to 0; in_frame is set to 1; the state moves to PASS.
- PASS: every accepted beat is forwarded. An accepted beat with tlast increments ln_cnt. At the Y_ACTIVE-th tlast, in_frame is cleared and ln_cnt returns to 0.
- Accepted tuser while in_frame=1 (short or restarted frame): ln_cnt is set to 0, the beat is forwarded, and in_frame stays at 1.
- Switch: in PASS, if sel_i != active_o and in_frame=0, then active_o <= sel_i and the state moves to SYNC.
  - The frame-ending tlast beat counts as in_frame=0 from the next cycle.
  - The switch takes effect no earlier than the cycle after that beat.
- A sel_i toggle that returns to active_o before the frame ends causes no switch.
- Changes on sel_i are ignored while in SYNC. The request is re-evaluated in PASS once the first frame of the new source has completed.
- ln_cnt width is $clog2(Y_ACTIVE+1) bits and never exceeds Y_ACTIVE-1 while in_frame=1.
- Sources that ignore tready lose beats while the sink stalls. This is accepted and not detected.

## Timing
- Reset values: video_o.tvalid=0, tdata=0, tlast=0, tuser=0; active_o=0; switching_o=1; ln_cnt=0; in_frame=0.
- Latency: a beat accepted at cycle N appears on video_o at cycle N+1. tdata, tlast and tuser are copied unchanged.
- Output register loads when ~video_o.tvalid | video_o.tready.
- video_o.tvalid falls in the cycle after an unreplaced beat is taken by the sink.
- The output register is not flushed on a switch. A beat held by the sink stays until taken.
- switching_o rises in the cycle after the frame-ending beat is accepted. It falls in the cycle after the SOF beat is accepted.
- Minimum gap between the last beat of the old source and the first beat of the new source on video_o is 1 cycle (the SYNC cycle).
- Reset mid-frame: all state clears immediately. Output resumes only at the next SOF of source 0.

## Configuration
- VIDEO_FRAME_MUX_CNT_EN defined:
  - Adds output frame_cnt_o, 16 bits, reset value 0.
  - Increments on each forwarded beat with tuser=1 and wraps from 0xFFFF to 0.
  - Adds output drop_cnt_o, 16 bits, reset value 0.
  - drop_cnt_o increments on each beat discarded from the granted source in SYNC and saturates at 0xFFFF.
- VIDEO_FRAME_MUX_CNT_EN undefined: neither port nor any counter logic exists. All other behaviour is identical.

## Test plan
- Reset with both sources running (X_ACTIVE=16, Y_ACTIVE=4, 8-cycle blanking), sel_i=0 -> output empty until source 0 SOF; then exactly 16x4 beats per frame, tuser only on the first beat, 4 tlast beats.
- sel_i 0->1 at line 2 pixel 5 -> source 0 frame completes (4 tlast beats); switching_o=1; first output beat after that is source 1 tuser beat; no source 1 beat before it.
- sel_i 0->1->0 pulse within one frame -> no switch; active_o stays 0; switching_o stays 0.
- Random video_o.tready (50%) with tready-honouring sources -> output stream is bit-identical to the granted source's input; tvalid never drops while an unconsumed beat is held.
- Source 0 restarts with tuser at line 2 -> ln_cnt reset; a switch requested then occurs only after 4 further tlast beats.
- With VIDEO_FRAME_MUX_CNT_EN: 3 frames passed, then a switch 10 beats before source 1 SOF -> frame_cnt_o=3 before the switch; drop_cnt_o=10 after the switch; frame_cnt_o=4 after the new SOF.

Source files
------------

// File: rtl/axi4_video_frame_mux_if.sv
// AXI4-Stream video bus used by axi4_video_frame_mux.
// tuser marks start of frame, tlast marks end of line.
interface axi4_stream_if #(
    parameter int DW = 32
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;

    modport master (
        output tdata, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/axi4_video_frame_mux.sv
// Frame-synchronous 2:1 AXI4-Stream video source scheduler.
// Optional counters: define VIDEO_FRAME_MUX_CNT_EN.
module axi4_video_frame_mux #(
    parameter int TDATA_WIDTH = 32,
    parameter int X_ACTIVE    = 1920,
    parameter int Y_ACTIVE    = 1080
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sel_i,
    axi4_stream_if.slave  video_0_i,
    axi4_stream_if.slave  video_1_i,
    axi4_stream_if.master video_o,
    output logic          active_o,
    output logic          switching_o
`ifdef VIDEO_FRAME_MUX_CNT_EN
    ,
    output logic [15:0]   frame_cnt_o,
    output logic [15:0]   drop_cnt_o
`endif
);
    localparam int LW = $clog2(Y_ACTIVE + 1);
    localparam logic [LW-1:0] LAST_LN = LW'(Y_ACTIVE - 1);

    if (X_ACTIVE < 1 || Y_ACTIVE < 1) begin : g_bad_cfg
        $error("axi4_video_frame_mux: bad geometry");
    end

    typedef enum logic {SYNC, PASS} state_t;

    state_t           state_q, state_d;
    logic             active_q, active_d;
    logic [LW-1:0]    ln_cnt_q, ln_cnt_d;
    logic             in_frame_q, in_frame_d;
    logic             ovalid_q;
    logic [TDATA_WIDTH-1:0] odata_q;
    logic             olast_q;
    logic             ouser_q;

    logic                   g_valid;
    logic [TDATA_WIDTH-1:0] g_data;
    logic                   g_last;
    logic                   g_user;
    logic                   g_ready;
    logic                   ld;
    logic                   req;
    logic                   in_pass;
    logic                   drain;
    logic                   acc;
    logic                   fwd;
    logic                   eof;
    logic [LW-1:0]          base;

    always_comb begin
        g_valid = active_q ? video_1_i.tvalid : video_0_i.tvalid;
        g_data  = active_q ? video_1_i.tdata  : video_0_i.tdata;
        g_last  = active_q ? video_1_i.tlast  : video_0_i.tlast;
        g_user  = active_q ? video_1_i.tuser  : video_0_i.tuser;
        ld      = ~ovalid_q | video_o.tready;
        req     = sel_i != active_q;
        in_pass = state_q == PASS;
        // Between frames a pending request drains the old source.
        drain   = in_pass & req & ~in_frame_q;
        if (drain) begin
            g_ready = 1'b1;
        end else if (!in_pass) begin
            // SOF waits for room; everything before it is dropped.
            g_ready = ~g_user | ld;
        end else begin
            g_ready = ld;
        end
        acc  = g_valid & g_ready;
        fwd  = acc & ~drain & (in_pass | g_user);
        base = g_user ? '0 : ln_cnt_q;
        eof  = fwd & g_last & (base == LAST_LN);
    end

    always_comb begin
        ln_cnt_d   = ln_cnt_q;
        in_frame_d = in_frame_q;
        state_d    = state_q;
        active_d   = active_q;
        if (fwd) begin
            in_frame_d = g_user | in_frame_q;
            ln_cnt_d   = base;
            if (eof) begin
                ln_cnt_d   = '0;
                in_frame_d = 1'b0;
            end else if (g_last) begin
                ln_cnt_d = base + LW'(1);
            end
        end
        if (!in_pass) begin
            if (fwd) state_d = PASS;
        end else if (req & (drain | eof)) begin
            state_d  = SYNC;
            active_d = sel_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= SYNC;
            active_q   <= 1'b0;
            ln_cnt_q   <= '0;
            in_frame_q <= 1'b0;
            ovalid_q   <= 1'b0;
            odata_q    <= '0;
            olast_q    <= 1'b0;
            ouser_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            ln_cnt_q   <= ln_cnt_d;
            in_frame_q <= in_frame_d;
            if (ld) begin
                ovalid_q <= fwd;
                if (fwd) begin
                    odata_q <= g_data;
                    olast_q <= g_last;
                    ouser_q <= g_user;
                end
            end
        end
    end

    assign video_0_i.tready = active_q ? 1'b1 : g_ready;
    assign video_1_i.tready = active_q ? g_ready : 1'b1;
    assign video_o.tvalid   = ovalid_q;
    assign video_o.tdata    = odata_q;
    assign video_o.tlast    = olast_q;
    assign video_o.tuser    = ouser_q;
    assign active_o         = active_q;
    assign switching_o      = state_q == SYNC;

`ifdef VIDEO_FRAME_MUX_CNT_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (fwd & g_user) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (acc & ~in_pass & ~g_user & (drop_cnt_q != 16'hFFFF))
                drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_axi4_video_frame_mux.sv
// Scoreboard bench for axi4_video_frame_mux (16x4 frames, 8-cycle blanking).
// Two honouring sources, frame-level model, random sink backpressure.
module tb_axi4_video_frame_mux;
    localparam int DW  = 32;
    localparam int XA  = 16;
    localparam int YA  = 4;
    localparam int GAP = 8;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic active;
    logic switching;
`ifdef VIDEO_FRAME_MUX_CNT_EN
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    axi4_stream_if #(.DW(DW)) s0 ();
    axi4_stream_if #(.DW(DW)) s1 ();
    axi4_stream_if #(.DW(DW)) mo ();

    axi4_video_frame_mux #(
        .TDATA_WIDTH(DW),
        .X_ACTIVE   (XA),
        .Y_ACTIVE   (YA)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .sel_i      (sel),
        .video_0_i  (s0),
        .video_1_i  (s1),
        .video_o    (mo),
        .active_o   (active),
        .switching_o(switching)
`ifdef VIDEO_FRAME_MUX_CNT_EN
        ,
        .frame_cnt_o(frame_cnt),
        .drop_cnt_o (drop_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // source generators
    int sx[2], sy[2], sfr[2], sgap[2];
    bit hs_prev[2];
    bit restart_req, restarted, src_stop;

    // model and monitor state
    logic [33:0] sbq[$];
    bit m_act, m_sync, m_in;
    int m_ln, m_frames, m_drops;
    bit rnd;
    bit prev_valid, prev_hs, prev_sw;
    logic [33:0] prev_word;
    int out_src, lasts, beats, frames_out, srcchg, sw_rises;

    function automatic logic [31:0] pix(input int s);
        logic [31:0] v;
        v = {7'd0, s[0], sfr[s][7:0], sy[s][7:0], sx[s][7:0]};
        return v;
    endfunction

    task automatic advance(input int s);
        if (hs_prev[s]) begin
            sx[s]++;
            if (sx[s] == XA) begin
                sx[s] = 0;
                sgap[s] = GAP;
                sy[s]++;
                if (s == 0 && restart_req && sy[s] == 2) begin
                    sy[s] = 0;
                    restart_req = 0;
                    restarted = 1;
                end
                if (sy[s] == YA) begin
                    sy[s] = 0;
                    sfr[s]++;
                end
            end
        end else if (sgap[s] > 0) begin
            sgap[s]--;
        end
    endtask

    task automatic drive_src();
        s0.tvalid = (sgap[0] == 0) && !src_stop;
        s0.tdata  = pix(0);
        s0.tuser  = sx[0] == 0 && sy[0] == 0;
        s0.tlast  = sx[0] == XA - 1;
        s1.tvalid = (sgap[1] == 0) && !src_stop;
        s1.tdata  = pix(1);
        s1.tuser  = sx[1] == 0 && sy[1] == 0;
        s1.tlast  = sx[1] == XA - 1;
    endtask

    task automatic model(input bit h0, input bit h1,
                         input logic [33:0] w0, input logic [33:0] w1);
        bit hg;
        bit req;
        logic [33:0] w;
        hg  = m_act ? h1 : h0;
        w   = m_act ? w1 : w0;
        req = sel != m_act;
        if (m_sync) begin
            if (hg && w[33]) begin
                sbq.push_back(w);
                m_sync = 0;
                m_in = 1;
                m_ln = w[32] ? 1 : 0;
                m_frames++;
            end else if (hg) begin
                m_drops++;
            end
        end else if (req && !m_in) begin
            m_act = sel;
            m_sync = 1;
        end else if (hg) begin
            sbq.push_back(w);
            if (w[33]) begin
                m_ln = 0;
                m_in = 1;
                m_frames++;
            end
            if (w[32]) begin
                m_ln++;
                if (m_ln == YA) begin
                    m_ln = 0;
                    m_in = 0;
                    if (req) begin
                        m_act = sel;
                        m_sync = 1;
                    end
                end
            end
        end
    endtask

    task automatic monitor_pop(input logic [33:0] word);
        logic [33:0] exp;
        int src;
        if (sbq.size() == 0) begin
            check("sb_nonempty", 64'(sbq.size()), 64'd1);
            return;
        end
        exp = sbq.pop_front();
        check("out_beat", word, exp);
        src = int'(word[24]);
        if (out_src < 0) begin
            check("first_is_sof", word[33], 1'b1);
        end else if (src != out_src) begin
            srcchg++;
            check("switch_sof", word[33], 1'b1);
            check("old_frame_lasts", lasts, YA);
        end else if (word[33] && lasts == YA) begin
            check("frame_beats", beats, XA * YA);
        end
        if (word[33]) begin
            lasts = 0;
            beats = 0;
            frames_out++;
        end
        beats++;
        if (word[32]) lasts++;
        out_src = src;
    endtask

    task automatic step();
        bit h0, h1, ho;
        logic [33:0] w0, w1, wo;
        if (!rst) begin
            check("active", active, m_act);
            check("switching", switching, m_sync);
            if (prev_valid && !prev_hs) begin
                check("hold_valid", mo.tvalid, 1'b1);
                check("hold_data", {mo.tuser, mo.tlast, mo.tdata},
                      prev_word);
            end
            if (switching && !prev_sw) sw_rises++;
            prev_sw = switching;
        end
        advance(0);
        advance(1);
        drive_src();
        mo.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        h0 = s0.tvalid & s0.tready;
        h1 = s1.tvalid & s1.tready;
        ho = mo.tvalid & mo.tready;
        w0 = {s0.tuser, s0.tlast, s0.tdata};
        w1 = {s1.tuser, s1.tlast, s1.tdata};
        wo = {mo.tuser, mo.tlast, mo.tdata};
        if (!rst) begin
            if (ho) monitor_pop(wo);
            model(h0, h1, w0, w1);
            prev_valid = mo.tvalid;
            prev_hs = ho;
            prev_word = wo;
        end
        hs_prev[0] = h0;
        hs_prev[1] = h1;
        @(negedge clk);
    endtask

    task automatic wait_pos(input int s, input int y, input int x);
        int n;
        n = 0;
        while (!(sy[s] == y && sx[s] == x && sgap[s] == 0) && n < 2000) begin
            step();
            n++;
        end
        check("wait_pos", 64'(n < 2000), 64'd1);
    endtask

    task automatic model_reset();
        m_act = 0;
        m_sync = 1;
        m_in = 0;
        m_ln = 0;
        m_frames = 0;
        m_drops = 0;
        sbq.delete();
        out_src = -1;
        prev_valid = 0;
        prev_hs = 0;
        prev_sw = 1;
    endtask

    int n0, n1;

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        rnd = 0;
        src_stop = 0;
        restart_req = 0;
        restarted = 0;
        for (int i = 0; i < 2; i++) begin
            sx[i] = 0;
            sy[i] = 0;
            sfr[i] = 0;
            sgap[i] = 0;
            hs_prev[i] = 0;
        end
        // source 1 free-runs half a frame out of phase
        sy[1] = 2;
        sx[1] = 7;
        lasts = 0;
        beats = 0;
        frames_out = 0;
        srcchg = 0;
        sw_rises = 0;
        model_reset();
        mo.tready = 1'b1;
        @(negedge clk);
        repeat (3) step();
        check("rst_tvalid", mo.tvalid, 1'b0);
        check("rst_tdata", mo.tdata, 32'd0);
        check("rst_tlast", mo.tlast, 1'b0);
        check("rst_tuser", mo.tuser, 1'b0);
        check("rst_active", active, 1'b0);
        check("rst_switching", switching, 1'b1);
        rst = 1'b0;

        repeat (400) step();
        check("p1_frames_ge3", 64'(frames_out >= 3), 64'd1);
        check("p1_src0", 64'(out_src), 64'd0);

        // short 0->1->0 pulse inside a frame
        wait_pos(0, 1, 3);
        n0 = sw_rises;
        sel = 1'b1;
        repeat (5) step();
        sel = 1'b0;
        repeat (200) step();
        check("pulse_active", active, 1'b0);
        check("pulse_no_switch", 64'(sw_rises - n0), 64'd0);

        // switch request mid-frame
        wait_pos(0, 2, 5);
        n0 = sw_rises;
        n1 = srcchg;
        sel = 1'b1;
        repeat (300) step();
        check("sw_active", active, 1'b1);
        check("sw_rises", 64'(sw_rises - n0), 64'd1);
        check("sw_out_change", 64'(srcchg - n1), 64'd1);

`ifdef VIDEO_FRAME_MUX_CNT_EN
        check("frame_cnt", frame_cnt, 16'(m_frames));
        check("drop_cnt", drop_cnt, 16'(m_drops));
`endif

        rnd = 1;
        repeat (600) step();
        rnd = 0;

        wait_pos(1, 1, 2);
        sel = 1'b0;
        repeat (300) step();
        check("back_active", active, 1'b0);

        // restart source 0 at line 2, then request a switch
        wait_pos(0, 0, 4);
        restart_req = 1;
        n0 = 0;
        while (!restarted && n0 < 500) begin
            step();
            n0++;
        end
        check("restart_seen", 64'(restarted), 64'd1);
        n1 = srcchg;
        sel = 1'b1;
        repeat (300) step();
        check("rs_active", active, 1'b1);
        check("rs_out_change", 64'(srcchg - n1), 64'd1);

`ifdef VIDEO_FRAME_MUX_CNT_EN
        check("frame_cnt2", frame_cnt, 16'(m_frames));
        check("drop_cnt2", drop_cnt, 16'(m_drops));
`endif

        // reset mid-frame, source 0 requested afterwards
        wait_pos(1, 1, 4);
        rst = 1'b1;
        sel = 1'b0;
        step();
        check("mrst_tvalid", mo.tvalid, 1'b0);
        check("mrst_active", active, 1'b0);
        check("mrst_switching", switching, 1'b1);
        step();
        model_reset();
        n0 = frames_out;
        rst = 1'b0;
        repeat (300) step();
        check("mrst_resume", 64'(frames_out > n0), 64'd1);
        check("mrst_src0", 64'(out_src), 64'd0);

        src_stop = 1;
        repeat (6) step();
        check("sb_drained", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
